// File: rtl/sort_floats_seq.sv
// Sequential bubble sorter for N floats: one shared f_less_or_equal, fixed N(N-1)/2 compare schedule.
// Optional macro SORT_FLOATS_SEQ_ERR_ABORT_EN ends the sort at the first comparator error.

module f_less_or_equal #(
   parameter int FLEN = 64
) (
   input  logic [FLEN-1:0] a,
   input  logic [FLEN-1:0] b,
   output logic            res,
   output logic            err
);
   localparam int EW = (FLEN == 16) ? 5 : (FLEN == 32) ? 8 : 11;
   localparam int MW = FLEN - 1 - EW;

   logic a_nan, b_nan, both_zero, mag_le, mag_ge;

   assign a_nan     = (&a[FLEN-2 -: EW]) && (|a[MW-1:0]);
   assign b_nan     = (&b[FLEN-2 -: EW]) && (|b[MW-1:0]);
   // +0 and -0 compare equal even though their sign bits differ.
   assign both_zero = ~|{a[FLEN-2:0], b[FLEN-2:0]};
   assign mag_le    = a[FLEN-2:0] <= b[FLEN-2:0];
   assign mag_ge    = a[FLEN-2:0] >= b[FLEN-2:0];

   always_comb begin
      err = a_nan | b_nan;
      if (err)                       res = 1'b0;
      else if (both_zero)            res = 1'b1;
      else if (a[FLEN-1] != b[FLEN-1]) res = a[FLEN-1];
      else if (a[FLEN-1])            res = mag_ge;
      else                           res = mag_le;
   end
endmodule

module sort_floats_seq #(
   parameter int N    = 4,
   parameter int FLEN = 64   // FP64, matching the shared configuration
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     up_valid,
   output logic                     up_ready,
   input  logic [0:N-1][FLEN-1:0]   up_data,
   output logic                     down_valid,
   input  logic                     down_ready,
   output logic [0:N-1][FLEN-1:0]   down_data,
   output logic                     down_err
);
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST_P = CW'(N - 2);

   typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

   state_t                   state_q, state_d;
   logic [0:N-1][FLEN-1:0]   vec_q, vec_d;
   logic [CW-1:0]            p_q, p_d, i_q, i_d;
   logic                     err_q, err_d;
   logic [FLEN-1:0]          cmp_a, cmp_b;
   logic                     cmp_res, cmp_err;

   assign cmp_a = vec_q[i_q];
   assign cmp_b = vec_q[i_q + CW'(1)];

   f_less_or_equal #(.FLEN(FLEN)) u_cmp (
      .a   (cmp_a),
      .b   (cmp_b),
      .res (cmp_res),
      .err (cmp_err)
   );

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      state_d = state_q;
      vec_d   = vec_q;
      p_d     = p_q;
      i_d     = i_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (up_valid) begin
               vec_d   = up_data;
               err_d   = 1'b0;
               p_d     = '0;
               i_d     = '0;
               state_d = SORT;
            end
         end
         SORT: begin
            // Equal values are never swapped, which keeps the sort stable.
            if (!cmp_res) begin
               vec_d[i_q]           = cmp_b;
               vec_d[i_q + CW'(1)]  = cmp_a;
            end
            err_d = err_q | cmp_err;
            if (i_q == LAST_P - p_q) begin
               i_d = '0;
               p_d = p_q + CW'(1);
            end else begin
               i_d = i_q + CW'(1);
            end
            if (p_q == LAST_P && i_q == '0) state_d = DONE;
`ifdef SORT_FLOATS_SEQ_ERR_ABORT_EN
            if (cmp_err) state_d = DONE;
`else
`endif
         end
         DONE: begin
            if (down_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the element array is reset too, so no stale vector survives a mid-sort reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         p_q     <= '0;
         i_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         p_q     <= p_d;
         i_q     <= i_d;
         err_q   <= err_d;
      end
   end

   assign up_ready   = (state_q == IDLE);
   assign down_valid = (state_q == DONE);
   assign down_data  = down_valid ? vec_q : '0;
   assign down_err   = down_valid & err_q;
endmodule

// File: tb/tb_sort_floats_seq.sv
// Directed bench for sort_floats_seq with N=4 FP64 vectors and hand-computed results.
// Expected latency for the NaN vector follows SORT_FLOATS_SEQ_ERR_ABORT_EN.

module tb_sort_floats_seq;
   localparam int N = 4;
   localparam int FLEN = 64;
   typedef logic [0:N-1][FLEN-1:0] vec_t;

   localparam logic [63:0] P1  = 64'h3FF0_0000_0000_0000;
   localparam logic [63:0] P2  = 64'h4000_0000_0000_0000;
   localparam logic [63:0] P3  = 64'h4008_0000_0000_0000;
   localparam logic [63:0] M1  = 64'hBFF0_0000_0000_0000;
   localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

`ifdef SORT_FLOATS_SEQ_ERR_ABORT_EN
   localparam int NAN_LAT = 2;
`else
   localparam int NAN_LAT = 7;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic up_valid = 1'b0;
   logic up_ready;
   vec_t up_data = '0;
   logic down_valid;
   logic down_ready = 1'b1;
   vec_t down_data;
   logic down_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sort_floats_seq #(.N(N), .FLEN(FLEN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_data    (up_data),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_data  (down_data),
      .down_err   (down_err)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offers one vector and returns edges from the accept edge (inclusive) until down_valid.
   task automatic send(input string name, input vec_t v, output int lat);
      @(negedge clk);
      check({name, "_up_ready_idle"}, up_ready, 1);
      up_data  = v;
      up_valid = 1'b1;
      @(posedge clk);
      #1;
      up_valid = 1'b0;
      lat = 1;
      while (!down_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run(input string name, input vec_t v, input vec_t exp, input logic exp_err,
                      input int exp_lat, input logic chk_data);
      int lat;
      send(name, v, lat);
      check({name, "_latency"}, lat, exp_lat);
      check({name, "_down_valid"}, down_valid, 1);
      if (chk_data) check({name, "_data"}, down_data, exp);
      check({name, "_err"}, down_err, exp_err);
      check({name, "_up_ready_busy"}, up_ready, 0);
      @(posedge clk);
      #1;
      check({name, "_valid_drop"}, down_valid, 0);
      check({name, "_up_ready_after"}, up_ready, 1);
   endtask

   initial begin
      int lat;
      #1;
      check("rst_up_ready", up_ready, 1);
      check("rst_down_valid", down_valid, 0);
      check("rst_down_err", down_err, 0);
      check("rst_down_data", down_data, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run("t1_mixed", {P3, P1, P2, M1}, {M1, P1, P2, P3}, 1'b0, 7, 1'b1);
      run("t2_sorted", {M1, P1, P2, P3}, {M1, P1, P2, P3}, 1'b0, 7, 1'b1);
      run("t3_dups", {P2, P1, P2, P1}, {P1, P1, P2, P2}, 1'b0, 7, 1'b1);

      down_ready = 1'b0;
      send("t4_stall", {P2, P3, M1, P1}, lat);
      check("t4_latency", lat, 7);
      for (int k = 0; k < 5; k++) begin
         check("t4_hold_valid", down_valid, 1);
         check("t4_hold_data", down_data, {M1, P1, P2, P3});
         check("t4_hold_err", down_err, 0);
         check("t4_hold_up_ready", up_ready, 0);
         @(posedge clk);
         #1;
      end
      check("t4_still_valid", down_valid, 1);
      down_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t4_valid_drop", down_valid, 0);
      check("t4_up_ready_after", up_ready, 1);

      run("t5_nan", {P1, QNAN, P2, P3}, '0, 1'b1, NAN_LAT, 1'b0);

      @(negedge clk);
      up_data  = {P3, P1, P2, M1};
      up_valid = 1'b1;
      @(posedge clk);
      #1;
      up_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("t6_in_sort", up_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_down_valid", down_valid, 0);
      check("t6_rst_up_ready", up_ready, 1);
      check("t6_rst_down_data", down_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run("t6_after_rst", {P3, P2, P1, M1}, {M1, P1, P2, P3}, 1'b0, 7, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
